// File: rtl/freeway_pkg.sv
// Shared constants for the freeway game: direction codes, FSM states and the
// visible screen size used by the sprite movement and the display path.
package freeway_pkg;

   // Direction codes as held by the direction controller
   localparam logic [3:0] DIR_DIREITA  = 4'b0011;
   localparam logic [3:0] DIR_BAIXO    = 4'b1100;
   localparam logic [3:0] DIR_ESQUERDA = 4'b0001;
   localparam logic [3:0] DIR_CIMA     = 4'b0100;

   // Visible field in pixels
   localparam int LARGURA_TELA = 640;
   localparam int ALTURA_TELA  = 480;

   // Player state machine
   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      STUN  = 2'd1,
      SCORE = 2'd2
   } estado_t;

endpackage

// File: rtl/contador_bcd.sv
// Two-digit saturating BCD counter. Each cycle with inc high adds one;
// units wrap 9->0 with a carry into tens, and the count holds at 99.
// Shared with the 7-segment display path, so it has no game knowledge.
module contador_bcd (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   output logic [7:0] valor
);

   logic [3:0] unidades_reg;
   logic [3:0] dezenas_reg;

   // Increment the BCD pair, saturating once both digits read 9
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         unidades_reg <= 4'd0;
         dezenas_reg  <= 4'd0;
      end else if (inc && !(dezenas_reg == 4'd9 && unidades_reg == 4'd9)) begin
         if (unidades_reg == 4'd9) begin
            unidades_reg <= 4'd0;
            dezenas_reg  <= dezenas_reg + 4'd1;
         end else begin
            unidades_reg <= unidades_reg + 4'd1;
         end
      end
   end

   assign valor = {dezenas_reg, unidades_reg};

endmodule

// File: rtl/movimento_galinha.sv
// Chicken sprite movement for the freeway game: steps the sprite on each game
// tick according to the held direction code, handles the stun/knockback after
// a car hit, and scores a point when the top of the field is reached.
// Optional build macro WRAP_X_EN: horizontal moves wrap around the field edges
// instead of clamping. Vertical moves always clamp.
module movimento_galinha
   import freeway_pkg::*;
#(
   parameter int STEP       = 8,
   parameter int X_START    = 316,
   parameter int Y_START    = 464,
   parameter int X_MAX      = LARGURA_TELA - 8,
   parameter int Y_GOAL     = 16,
   parameter int KNOCK      = 32,
   parameter int STUN_TICKS = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] dir_code,
   input  logic       tick,
   input  logic       colisao,
   output logic [9:0] pos_x,
   output logic [8:0] pos_y,
   output logic [7:0] placar,
   output logic       ponto,
   output logic       atordoado
);

   // Constants sized one bit wider than the positions so sums never wrap
   localparam logic [10:0] STEP_X   = 11'(STEP);
   localparam logic [10:0] XMAX_X   = 11'(X_MAX);
   localparam logic [9:0]  X_INI    = 10'(X_START);
   localparam logic [9:0]  STEP_Y   = 10'(STEP);
   localparam logic [9:0]  YSTART_Y = 10'(Y_START);
   localparam logic [9:0]  KNOCK_Y  = 10'(KNOCK);
   localparam logic [9:0]  GOAL_Y   = 10'(Y_GOAL);
   localparam logic [8:0]  Y_INI    = 9'(Y_START);
   localparam logic [7:0]  STUN_INI = 8'(STUN_TICKS);

   estado_t    estado_reg;
   logic [9:0] pos_x_reg;
   logic [8:0] pos_y_reg;
   logic [7:0] stun_cnt_reg;
   logic       ponto_reg;
   logic       atordoado_reg;

   logic [10:0] x_larga, soma_x, dif_x;
   logic [9:0]  y_larga, soma_y, dif_y, soma_k;
   logic [9:0]  x_direita, x_esquerda;
   logic [8:0]  y_baixo, y_cima, y_knock;
   logic        chega_meta;

   // Candidate positions for every move, computed wide and then clamped/wrapped
   always_comb begin
      x_larga = {1'b0, pos_x_reg};
      y_larga = {1'b0, pos_y_reg};
      soma_x  = x_larga + STEP_X;
      dif_x   = x_larga - STEP_X;
      soma_y  = y_larga + STEP_Y;
      dif_y   = y_larga - STEP_Y;
      soma_k  = y_larga + KNOCK_Y;
`ifdef WRAP_X_EN
      x_direita  = (soma_x > XMAX_X)  ? 10'd0        : 10'(soma_x);
      x_esquerda = (x_larga < STEP_X) ? 10'(XMAX_X)  : 10'(dif_x);
`else
      x_direita  = (soma_x > XMAX_X)  ? 10'(XMAX_X)  : 10'(soma_x);
      x_esquerda = (x_larga < STEP_X) ? 10'd0        : 10'(dif_x);
`endif
      y_baixo    = (soma_y > YSTART_Y) ? Y_INI : 9'(soma_y);
      y_cima     = (y_larga < STEP_Y)  ? 9'd0  : 9'(dif_y);
      y_knock    = (soma_k > YSTART_Y) ? Y_INI : 9'(soma_k);
      chega_meta = ({1'b0, y_cima} <= GOAL_Y);
   end

   // Player FSM with registered position, stun counter and status outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         estado_reg    <= PLAY;
         pos_x_reg     <= X_INI;
         pos_y_reg     <= Y_INI;
         stun_cnt_reg  <= 8'd0;
         ponto_reg     <= 1'b0;
         atordoado_reg <= 1'b0;
      end else begin
         ponto_reg <= 1'b0;
         case (estado_reg)
            PLAY: begin
               if (colisao) begin
                  // A hit wins over a simultaneous tick: knock back, no move
                  estado_reg    <= STUN;
                  pos_y_reg     <= y_knock;
                  stun_cnt_reg  <= STUN_INI;
                  atordoado_reg <= 1'b1;
               end else if (tick) begin
                  case (dir_code)
                     DIR_DIREITA:  pos_x_reg <= x_direita;
                     DIR_ESQUERDA: pos_x_reg <= x_esquerda;
                     DIR_BAIXO:    pos_y_reg <= y_baixo;
                     DIR_CIMA: begin
                        pos_y_reg <= y_cima;
                        if (chega_meta) begin
                           estado_reg <= SCORE;
                           ponto_reg  <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            STUN: begin
               // Frozen: only ticks matter, counting down to release
               if (tick) begin
                  if (stun_cnt_reg == 8'd1) begin
                     estado_reg    <= PLAY;
                     atordoado_reg <= 1'b0;
                     stun_cnt_reg  <= 8'd0;
                  end else begin
                     stun_cnt_reg <= stun_cnt_reg - 8'd1;
                  end
               end
            end
            SCORE: begin
               // Single cycle: respawn; any tick seen here is dropped
               estado_reg <= PLAY;
               pos_x_reg  <= X_INI;
               pos_y_reg  <= Y_INI;
            end
            default: estado_reg <= PLAY;
         endcase
      end
   end

   contador_bcd u_placar (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (estado_reg == SCORE),
      .valor   (placar)
   );

   assign pos_x     = pos_x_reg;
   assign pos_y     = pos_y_reg;
   assign ponto     = ponto_reg;
   assign atordoado = atordoado_reg;

endmodule
